// File: rtl/fifo_wr_arbiter.sv
// Packet-level round-robin arbiter sharing one FIFO write port among N_REQ valid/ready requesters.
// A granted requester keeps the port until its last beat is accepted, so packets never interleave.
module fifo_wr_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    input  logic [N_REQ-1:0]        req_last_i,
    output logic [N_REQ-1:0]        req_ready_o,
    input  logic                    fifo_full_i,
    output logic                    fifo_wr_en_o,
    output logic [DATA_W-1:0]       fifo_data_o,
    output logic [N_REQ-1:0]        grant_o,
    output logic                    busy_o,
    output logic [CNT_W-1:0]        pkt_cnt_o,
    output logic [CNT_W-1:0]        stall_cnt_o
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]        state_r;
    logic [N_REQ-1:0]  grant_r;
    logic [PTR_W-1:0]  rr_ptr_r;
    logic [CNT_W-1:0]  pkt_cnt_r;
    logic [CNT_W-1:0]  stall_cnt_r;

    logic [0:0]        state_nxt_s;
    logic [N_REQ-1:0]  grant_nxt_s;
    logic [PTR_W-1:0]  ptr_nxt_s;
    logic [PTR_W-1:0]  owner_s;
    logic [PTR_W-1:0]  hand_ptr_s;
    logic [N_REQ-1:0]  pick_idle_s;
    logic [N_REQ-1:0]  pick_hand_s;
    logic              own_valid_s;
    logic              own_last_s;
    logic              wr_en_s;
    logic              last_acc_s;
    logic              stall_s;
    logic [DATA_W-1:0] data_s;

    // First valid index scanning upward from ptr with wrap, returned one-hot.
    function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] vld,
                                                 input logic [PTR_W-1:0] ptr);
        logic [N_REQ-1:0] pick;
        logic             found;
        logic [PTR_W-1:0] idx_p;
        int               idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            idx_p = PTR_W'(idx);
            if (!found && vld[idx_p]) begin
                pick[idx_p] = 1'b1;
                found       = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [PTR_W-1:0] oh_to_idx(input logic [N_REQ-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (oh[k]) idx = PTR_W'(k);
        end
        return idx;
    endfunction

    // Owner-side datapath; grant_r is zero in IDLE so every term below idles at 0.
    always_comb begin
        data_s = '0;
        for (int k = 0; k < N_REQ; k++) begin
            data_s = data_s | (req_data_i[k*DATA_W +: DATA_W] & {DATA_W{grant_r[k]}});
        end
        own_valid_s = |(grant_r & req_valid_i);
        own_last_s  = |(grant_r & req_valid_i & req_last_i);
        wr_en_s     = own_valid_s & ~fifo_full_i;
        last_acc_s  = own_last_s & ~fifo_full_i;
        stall_s     = own_valid_s & fifo_full_i;
        owner_s     = oh_to_idx(grant_r);
        hand_ptr_s  = (owner_s == PTR_W'(N_REQ - 1)) ? '0 : owner_s + PTR_W'(1);
        pick_idle_s = rr_pick(req_valid_i, rr_ptr_r);
        // The finishing owner is masked so it can only return via IDLE.
        pick_hand_s = rr_pick(req_valid_i & ~grant_r, hand_ptr_s);
    end

    // Next state, grant and round-robin pointer.
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        ptr_nxt_s   = rr_ptr_r;
        case (state_r)
            IDLE: begin
                if (|req_valid_i) begin
                    state_nxt_s = GRANT;
                    grant_nxt_s = pick_idle_s;
                end else begin
                    state_nxt_s = IDLE;
                    grant_nxt_s = '0;
                end
            end
            GRANT: begin
                if (last_acc_s) begin
                    ptr_nxt_s = hand_ptr_s;
                    if (|pick_hand_s) begin
                        state_nxt_s = GRANT;
                        grant_nxt_s = pick_hand_s;
                    end else begin
                        state_nxt_s = IDLE;
                        grant_nxt_s = '0;
                    end
                end else begin
                    state_nxt_s = GRANT;
                    grant_nxt_s = grant_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                grant_nxt_s = '0;
                ptr_nxt_s   = '0;
            end
        endcase
    end

    // FSM, grant and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            grant_r  <= '0;
            rr_ptr_r <= '0;
        end else begin
            state_r  <= state_nxt_s;
            grant_r  <= grant_nxt_s;
            rr_ptr_r <= ptr_nxt_s;
        end
    end

    // Packet counter wraps; stall counter saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_r   <= '0;
            stall_cnt_r <= '0;
        end else begin
            if (last_acc_s) begin
                pkt_cnt_r <= pkt_cnt_r + CNT_W'(1);
            end
            if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end
        end
    end

    assign req_ready_o  = grant_r & {N_REQ{~fifo_full_i}};
    assign fifo_wr_en_o = wr_en_s;
    assign fifo_data_o  = data_s;
    assign grant_o      = grant_r;
    assign busy_o       = (state_r == GRANT);
    assign pkt_cnt_o    = pkt_cnt_r;
    assign stall_cnt_o  = stall_cnt_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed vector table, hand-written corner sequences,
// then randomized traffic checked cycle by cycle against a packet-level reference model.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_data;
    logic [N-1:0]    grant;
    logic            busy;
    logic [CW-1:0]   pkt_cnt;
    logic [CW-1:0]   stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
        .req_ready_o(req_ready), .fifo_full_i(fifo_full),
        .fifo_wr_en_o(fifo_wr_en), .fifo_data_o(fifo_data),
        .grant_o(grant), .busy_o(busy), .pkt_cnt_o(pkt_cnt), .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic [3:0]  v;
        logic [3:0]  l;
        logic        f;
        logic [31:0] d;
        logic [3:0]  eg;
        logic [3:0]  er;
        logic        ew;
        logic [7:0]  ed;
        logic [15:0] ep;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack(input logic [3:0] g, input logic [3:0] r, input logic w,
                                         input logic [7:0] d, input logic b,
                                         input logic [15:0] p, input logic [15:0] s);
        return {14'd0, g, r, w, d, b, p, s};
    endfunction

    function automatic logic [63:0] outs();
        return pack(grant, req_ready, fifo_wr_en, fifo_data, busy, pkt_cnt, stall_cnt);
    endfunction

    function automatic vec_t mk(input logic rst, input logic [3:0] v, input logic [3:0] l,
                                input logic f, input logic [31:0] d, input logic [3:0] eg,
                                input logic [3:0] er, input logic ew, input logic [7:0] ed,
                                input logic [15:0] ep);
        vec_t e;
        e = {rst, v, l, f, d, eg, er, ew, ed, ep};
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic f, input logic [31:0] d);
        req_valid = v;
        req_last  = l;
        fifo_full = f;
        req_data  = d;
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Hard invariant: never write into a full FIFO.
    always @(negedge clk) begin
        if (rst_n === 1'b1) chk("no_wr_when_full", {63'd0, fifo_wr_en & fifo_full}, 64'd0);
    end

    // Reference model state for the randomized phase.
    int          m_owner;
    int          m_ptr;
    int          m_pkt;
    int          m_stall;
    int          rem[N];
    int          seqn[N];
    logic        cv[N];
    logic [7:0]  cd[N];
    logic        cl[N];

    initial begin
        rst_n = 1'b0;
        do_reset();
        chk("reset_state", outs(), 64'd0);

        // single packet from 1
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 0, 32'h0000A100, 4'b0000, 4'b0000, 0, 8'h00, 16'd0));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 0, 32'h0000A100, 4'b0010, 4'b0010, 1, 8'hA1, 16'd0));
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 0, 32'h0000A200, 4'b0010, 4'b0010, 1, 8'hA2, 16'd0));
        tbl.push_back(mk(0, 4'b0010, 4'b0010, 0, 32'h0000A300, 4'b0010, 4'b0010, 1, 8'hA3, 16'd0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 32'h00000000, 4'b0000, 4'b0000, 0, 8'h00, 16'd1));
        // all four request after reset, then wrap-around 0 vs 3
        tbl.push_back(mk(1, 4'b1111, 4'b0000, 0, 32'h31211101, 4'b0000, 4'b0000, 0, 8'h00, 16'd0));
        tbl.push_back(mk(0, 4'b1111, 4'b0000, 0, 32'h31211101, 4'b0001, 4'b0001, 1, 8'h01, 16'd0));
        tbl.push_back(mk(0, 4'b1111, 4'b0001, 0, 32'h31211102, 4'b0001, 4'b0001, 1, 8'h02, 16'd0));
        tbl.push_back(mk(0, 4'b1110, 4'b0000, 0, 32'h31211100, 4'b0010, 4'b0010, 1, 8'h11, 16'd1));
        tbl.push_back(mk(0, 4'b1110, 4'b0010, 0, 32'h31211200, 4'b0010, 4'b0010, 1, 8'h12, 16'd1));
        tbl.push_back(mk(0, 4'b1100, 4'b0000, 0, 32'h31210000, 4'b0100, 4'b0100, 1, 8'h21, 16'd2));
        tbl.push_back(mk(0, 4'b1100, 4'b0100, 0, 32'h31220000, 4'b0100, 4'b0100, 1, 8'h22, 16'd2));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 0, 32'h31000000, 4'b1000, 4'b1000, 1, 8'h31, 16'd3));
        tbl.push_back(mk(0, 4'b1000, 4'b1000, 0, 32'h32000000, 4'b1000, 4'b1000, 1, 8'h32, 16'd3));
        tbl.push_back(mk(0, 4'b1001, 4'b1001, 0, 32'h3A00000A, 4'b0000, 4'b0000, 0, 8'h00, 16'd4));
        tbl.push_back(mk(0, 4'b1001, 4'b1001, 0, 32'h3A00000A, 4'b0001, 4'b0001, 1, 8'h0A, 16'd4));
        tbl.push_back(mk(0, 4'b1000, 4'b1000, 0, 32'h3A000000, 4'b1000, 4'b1000, 1, 8'h3A, 16'd5));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 32'h00000000, 4'b0000, 4'b0000, 0, 8'h00, 16'd6));

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            drive(tbl[i].v, tbl[i].l, tbl[i].f, tbl[i].d);
            chk($sformatf("vec%0d", i), outs(),
                pack(tbl[i].eg, tbl[i].er, tbl[i].ew, tbl[i].ed, (tbl[i].eg != 4'b0000),
                     tbl[i].ep, 16'd0));
            tick();
        end

        // Backpressure: requester 2 held off by a full FIFO for 5 cycles.
        drive(4'b0100, 4'b0000, 1'b1, 32'h005C0000);
        chk("bp_idle", outs(), pack(4'b0000, 4'b0000, 0, 8'h00, 0, 16'd6, 16'd0));
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(4'b0100, 4'b0000, 1'b1, 32'h005C0000);
            chk($sformatf("bp_hold%0d", i), outs(), pack(4'b0100, 4'b0000, 0, 8'h5C, 1, 16'd6, 16'(i)));
            tick();
        end
        drive(4'b0100, 4'b0000, 1'b0, 32'h005C0000);
        chk("bp_pop", outs(), pack(4'b0100, 4'b0100, 1, 8'h5C, 1, 16'd6, 16'd5));
        tick();
        drive(4'b0100, 4'b0100, 1'b1, 32'h005D0000);
        chk("bp_refull", outs(), pack(4'b0100, 4'b0000, 0, 8'h5D, 1, 16'd6, 16'd5));
        tick();
        drive(4'b0100, 4'b0100, 1'b0, 32'h005D0000);
        chk("bp_last", outs(), pack(4'b0100, 4'b0100, 1, 8'h5D, 1, 16'd6, 16'd6));
        tick();

        // Owner gap: owner 3 drops valid for 3 cycles while requester 0 waits.
        drive(4'b1000, 4'b0000, 1'b0, 32'h71000000);
        chk("gap_idle", outs(), pack(4'b0000, 4'b0000, 0, 8'h00, 0, 16'd7, 16'd6));
        tick();
        drive(4'b1000, 4'b0000, 1'b0, 32'h71000000);
        chk("gap_beat1", outs(), pack(4'b1000, 4'b1000, 1, 8'h71, 1, 16'd7, 16'd6));
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(4'b0001, 4'b0001, 1'b0, 32'h7200000F);
            chk($sformatf("gap_hold%0d", i), outs(), pack(4'b1000, 4'b1000, 0, 8'h72, 1, 16'd7, 16'd6));
            tick();
        end
        drive(4'b1001, 4'b1001, 1'b0, 32'h7200000F);
        chk("gap_last", outs(), pack(4'b1000, 4'b1000, 1, 8'h72, 1, 16'd7, 16'd6));
        tick();
        drive(4'b0001, 4'b0001, 1'b0, 32'h0000000F);
        chk("gap_handover", outs(), pack(4'b0001, 4'b0001, 1, 8'h0F, 1, 16'd8, 16'd6));
        tick();
        drive(4'b0000, 4'b0000, 1'b0, 32'h00000000);
        chk("gap_done", outs(), pack(4'b0000, 4'b0000, 0, 8'h00, 0, 16'd9, 16'd6));
        tick();

        // Reset during beat 2 of 4 from requester 2 (pointer is non-zero here).
        drive(4'b0100, 4'b0000, 1'b0, 32'h00B10000);
        tick();
        drive(4'b0100, 4'b0000, 1'b0, 32'h00B10000);
        chk("rst_beat1", outs(), pack(4'b0100, 4'b0100, 1, 8'hB1, 1, 16'd9, 16'd6));
        tick();
        drive(4'b0100, 4'b0000, 1'b0, 32'h00B20000);
        rst_n = 1'b0;
        #1;
        chk("rst_async", outs(), 64'd0);
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        drive(4'b0101, 4'b0001, 1'b0, 32'h00C200C0);
        chk("rst_idle", outs(), 64'd0);
        tick();
        drive(4'b0101, 4'b0001, 1'b0, 32'h00C200C0);
        chk("rst_ptr0", outs(), pack(4'b0001, 4'b0001, 1, 8'hC0, 1, 16'd0, 16'd0));
        tick();
        drive(4'b0100, 4'b0100, 1'b0, 32'h00C20000);
        chk("rst_next", outs(), pack(4'b0100, 4'b0100, 1, 8'hC2, 1, 16'd1, 16'd0));
        tick();

        // Randomized traffic against the packet-level model.
        do_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_pkt   = 0;
        m_stall = 0;
        for (int r = 0; r < N; r++) begin
            rem[r] = 0; seqn[r] = 0; cv[r] = 1'b0; cd[r] = 8'h00; cl[r] = 1'b0;
        end
        for (int c = 0; c < 3000; c++) begin
            logic [3:0]  v, l, eg, er;
            logic [31:0] d;
            logic        f, ew, acc, found;
            logic [7:0]  ed;
            for (int r = 0; r < N; r++) begin
                if (!cv[r]) begin
                    if (rem[r] == 0 && $urandom_range(0, 3) == 0) rem[r] = $urandom_range(1, 4);
                    if (rem[r] > 0 && $urandom_range(0, 2) != 0) begin
                        cv[r]   = 1'b1;
                        seqn[r] = seqn[r] + 1;
                        cd[r]   = 8'(r * 64 + seqn[r] % 64);
                        cl[r]   = (rem[r] == 1);
                    end
                end
                v[r] = cv[r] && !(r == m_owner && $urandom_range(0, 7) == 0);
                l[r] = cl[r];
                d[r*8 +: 8] = cd[r];
            end
            f = ($urandom_range(0, 3) == 0);
            drive(v, l, f, d);

            eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
            er = f ? 4'b0000 : eg;
            ew = (m_owner >= 0) && v[m_owner] && !f;
            ed = (m_owner >= 0) ? cd[m_owner] : 8'h00;
            chk($sformatf("rand%0d", c), outs(),
                pack(eg, er, ew, ed, (m_owner >= 0), 16'(m_pkt), 16'(m_stall)));

            acc = ew;
            if (m_owner >= 0 && v[m_owner] && f && m_stall < 65535) m_stall = m_stall + 1;
            if (m_owner < 0) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!found && v[(m_ptr + k) % N]) begin
                        m_owner = (m_ptr + k) % N;
                        found   = 1'b1;
                    end
                end
            end else if (acc) begin
                int g;
                g      = m_owner;
                cv[g]  = 1'b0;
                rem[g] = rem[g] - 1;
                if (cl[g]) begin
                    m_pkt   = m_pkt + 1;
                    m_ptr   = (g + 1) % N;
                    m_owner = -1;
                    found   = 1'b0;
                    for (int k = 0; k < N; k++) begin
                        if (!found && ((m_ptr + k) % N) != g && v[(m_ptr + k) % N]) begin
                            m_owner = (m_ptr + k) % N;
                            found   = 1'b1;
                        end
                    end
                end
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
